// File: rtl/ram_store_packer.sv
// ram_store_packer
// Reads num_beats*GROUP_SIZE consecutive words from a banked RAM read port,
// starting at base_addr and wrapping silently at 2^ADDR_WIDTH. It packs each
// group of GROUP_SIZE words into one MEM_DATA_WIDTH beat (lowest address in
// the LSBs) and presents the beats on a valid/ready stream.
//
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   start              launch a transfer (sampled only in IDLE)
//   base_addr          first word address, captured on start
//   num_beats          number of output beats, captured on start
//   busy, done         status: not-IDLE, one-cycle completion pulse
//   ram_read_req/addr  RAM read request and word address
//   ram_read_data      RAM read data, valid one cycle after the request
//   m_valid/m_ready    output beat handshake
//   m_data, m_last     packed beat and final-beat flag
//
// state | meaning
// IDLE  | waiting for start
// RUN   | issuing word reads and packing beats
// FLUSH | all reads issued; draining the final beat
// DONE  | one-cycle completion pulse
module ram_store_packer #(
  parameter int DATA_WIDTH     = 16,
  parameter int MEM_DATA_WIDTH = 64,
  parameter int ADDR_WIDTH     = 13,
  parameter int CNT_W          = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [ADDR_WIDTH-1:0]     base_addr,
  input  logic [CNT_W-1:0]          num_beats,
  output logic                      busy,
  output logic                      done,
  output logic                      ram_read_req,
  output logic [ADDR_WIDTH-1:0]     ram_read_addr,
  input  logic [DATA_WIDTH-1:0]     ram_read_data,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [MEM_DATA_WIDTH-1:0] m_data,
  output logic                      m_last
);

  localparam int GROUP_SIZE = MEM_DATA_WIDTH / DATA_WIDTH;
  localparam int PW         = $clog2(GROUP_SIZE + 1);
  localparam int WW         = CNT_W + $clog2(GROUP_SIZE) + 1;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t                    state;
  state_t                    state_nxt;
  logic [ADDR_WIDTH-1:0]     addr;
  logic [WW-1:0]             words_left;
  logic [CNT_W-1:0]          beats_left;
  logic [PW-1:0]             pack_cnt;
  logic                      inflight;
  logic [MEM_DATA_WIDTH-1:0] pack;
  logic                      handshake;
  logic                      load_beat;
  logic                      room;

  assign handshake     = m_valid & m_ready;
  // Full pack register moves to the output register when that slot is free
  // or being emptied this cycle.
  assign load_beat     = (pack_cnt == PW'(GROUP_SIZE)) && (!m_valid || m_ready);
  // A word already in flight has a reserved slot, so count it as occupied.
  assign room          = ((PW + 1)'(pack_cnt) + (PW + 1)'(inflight)) < (PW + 1)'(GROUP_SIZE);
  assign ram_read_addr = addr;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) state_nxt = (num_beats == '0) ? DONE : RUN;
      end
      RUN: begin
        if (ram_read_req && (words_left == WW'(1))) state_nxt = FLUSH;
      end
      FLUSH: begin
        if (handshake && m_last) state_nxt = DONE;
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy         = (state != IDLE);
    done         = (state == DONE);
    ram_read_req = (state == RUN) && (words_left != '0) && room;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr       <= '0;
      words_left <= '0;
      beats_left <= '0;
      pack_cnt   <= '0;
      inflight   <= 1'b0;
      pack       <= '0;
      m_valid    <= 1'b0;
      m_data     <= '0;
      m_last     <= 1'b0;
    end else begin
      inflight <= ram_read_req;

      if ((state == IDLE) && start) begin
        addr       <= base_addr;
        words_left <= WW'(num_beats) * WW'(GROUP_SIZE);
        beats_left <= num_beats;
        pack_cnt   <= '0;
      end

      if (ram_read_req) begin
        addr       <= addr + ADDR_WIDTH'(1);
        words_left <= words_left - WW'(1);
      end

      // A returning word and a full pack register never coincide: a read is
      // only issued while the in-flight word still leaves a free slot.
      if (inflight) begin
        for (int k = 0; k < GROUP_SIZE; k++) begin
          if (pack_cnt == PW'(k)) pack[k*DATA_WIDTH +: DATA_WIDTH] <= ram_read_data;
        end
        pack_cnt <= pack_cnt + PW'(1);
      end else if (load_beat) begin
        m_data     <= pack;
        m_last     <= (beats_left == CNT_W'(1));
        beats_left <= beats_left - CNT_W'(1);
        pack_cnt   <= '0;
      end

      if (load_beat) begin
        m_valid <= 1'b1;
      end else if (handshake) begin
        m_valid <= 1'b0;
        m_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ram_store_packer.sv
module tb_ram_store_packer;

  logic        clk;
  logic        reset;
  logic        start;
  logic [12:0] base_addr;
  logic [15:0] num_beats;
  logic        busy;
  logic        done;
  logic        ram_read_req;
  logic [12:0] ram_read_addr;
  logic [15:0] ram_read_data;
  logic        m_valid;
  logic        m_ready;
  logic [63:0] m_data;
  logic        m_last;

  ram_store_packer dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .base_addr     (base_addr),
    .num_beats     (num_beats),
    .busy          (busy),
    .done          (done),
    .ram_read_req  (ram_read_req),
    .ram_read_addr (ram_read_addr),
    .ram_read_data (ram_read_data),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_data        (m_data),
    .m_last        (m_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] mem [0:8191];
  always @(posedge clk) begin
    if (ram_read_req) ram_read_data <= mem[ram_read_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0] data;
    logic        last;
  } beat_t;

  beat_t       exp_q[$];
  logic [12:0] addr_q[$];

  int start_cyc   = 0;
  int reqs_seen   = 0;
  int first_req   = -1;
  int last_req    = -1;
  int first_valid = -1;
  int done_rel    = -1;
  int done_cnt    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: scoreboards read addresses and output beats, records timing.
  always @(negedge clk) begin
    int rel;
    beat_t b;
    rel = cyc - start_cyc;
    if (ram_read_req) begin
      reqs_seen++;
      if (first_req < 0) first_req = rel;
      last_req = rel;
      if (addr_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_read: got addr 0x%0h expected no read", ram_read_addr);
      end else begin
        chk("read_addr", 64'(ram_read_addr), 64'(addr_q.pop_front()));
      end
    end
    if (m_valid && first_valid < 0) first_valid = rel;
    if (done) begin
      done_cnt++;
      if (done_rel < 0) done_rel = rel;
    end
    if (m_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got data 0x%0h expected no beat", m_data);
      end else begin
        b = exp_q[0];
        chk(m_ready ? "beat_data" : "held_data", m_data, b.data);
        chk(m_ready ? "beat_last" : "held_last", 64'(m_last), 64'(b.last));
        if (m_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic push_beat(input logic [63:0] d, input logic l);
    beat_t b;
    b.data = d;
    b.last = l;
    exp_q.push_back(b);
  endtask

  task automatic push_addrs(input logic [12:0] b, input int n);
    logic [12:0] a;
    a = b;
    for (int i = 0; i < n; i++) begin
      addr_q.push_back(a);
      a = a + 13'd1;
    end
  endtask

  task automatic launch(input logic [12:0] b, input logic [15:0] n);
    @(posedge clk); #1;
    reqs_seen   = 0;
    first_req   = -1;
    last_req    = -1;
    first_valid = -1;
    done_rel    = -1;
    done_cnt    = 0;
    start_cyc   = cyc;
    start       = 1'b1;
    base_addr   = b;
    num_beats   = n;
    @(posedge clk); #1;
    start       = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int i;
    for (i = 0; i < 400; i++) begin
      @(negedge clk);
      if (done_rel >= 0) break;
    end
    if (i == 400) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no done expected done within 400 cycles", name);
    end
    repeat (2) @(negedge clk);
    chk({name, "_beats_left"}, 64'(exp_q.size()), 64'd0);
    chk({name, "_reads_left"}, 64'(addr_q.size()), 64'd0);
    chk({name, "_done_cnt"}, 64'(done_cnt), 64'd1);
    chk({name, "_idle"}, 64'(busy), 64'd0);
  endtask

  task automatic check_quiet(input string name);
    chk({name, "_busy"}, 64'(busy), 64'd0);
    chk({name, "_done"}, 64'(done), 64'd0);
    chk({name, "_req"}, 64'(ram_read_req), 64'd0);
    chk({name, "_valid"}, 64'(m_valid), 64'd0);
    chk({name, "_last"}, 64'(m_last), 64'd0);
  endtask

  initial begin
    int snap;
    int i;
    reset     = 1'b1;
    start     = 1'b0;
    base_addr = '0;
    num_beats = '0;
    m_ready   = 1'b1;
    for (int k = 0; k < 8192; k++) mem[k] = 16'h0;
    mem[13'h0010] = 16'h0001; mem[13'h0011] = 16'h0002;
    mem[13'h0012] = 16'h0003; mem[13'h0013] = 16'h0004;
    mem[13'h1FFE] = 16'hAAAA; mem[13'h1FFF] = 16'hBBBB;
    mem[13'h0000] = 16'hCCCC; mem[13'h0001] = 16'hDDDD;
    for (int k = 0; k < 12; k++) mem[13'h0100 + k] = 16'h1100 + 16'(k);
    for (int k = 0; k < 8; k++)  mem[13'h0200 + k] = 16'h2200 + 16'(k);

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_quiet("reset");

    // Single beat, nominal latency
    push_addrs(13'h0010, 4);
    push_beat(64'h0004_0003_0002_0001, 1'b1);
    launch(13'h0010, 16'd1);
    wait_done("basic");
    chk("basic_first_req", 64'(first_req), 64'd1);
    chk("basic_last_req", 64'(last_req), 64'd4);
    chk("basic_req_count", 64'(reqs_seen), 64'd4);
    chk("basic_first_valid", 64'(first_valid), 64'd7);
    chk("basic_done_cycle", 64'(done_rel), 64'd8);

    // Address wrap
    push_addrs(13'h1FFE, 4);
    push_beat(64'hDDDD_CCCC_BBBB_AAAA, 1'b1);
    launch(13'h1FFE, 16'd1);
    wait_done("wrap");

    // Backpressure on the first beat of three
    m_ready = 1'b0;
    push_addrs(13'h0100, 12);
    push_beat(64'h1103_1102_1101_1100, 1'b0);
    push_beat(64'h1107_1106_1105_1104, 1'b0);
    push_beat(64'h110B_110A_1109_1108, 1'b1);
    launch(13'h0100, 16'd3);
    for (i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (m_valid) break;
    end
    chk("bp_valid_seen", 64'(m_valid), 64'd1);
    snap = reqs_seen;
    repeat (10) begin
      @(posedge clk); #1;
    end
    chk("bp_further_reads_le4", 64'((reqs_seen - snap) <= 4), 64'd1);
    m_ready = 1'b1;
    wait_done("bp");
    chk("bp_req_count", 64'(reqs_seen), 64'd12);

    // Zero beats
    launch(13'h0040, 16'd0);
    wait_done("zero");
    chk("zero_req_count", 64'(reqs_seen), 64'd0);
    chk("zero_valid_seen", 64'(first_valid), 64'hFFFF_FFFF_FFFF_FFFF);
    chk("zero_done_cycle", 64'(done_rel), 64'd1);

    // Reset mid-transfer after 5 of 8 words issued
    push_addrs(13'h0200, 8);
    push_beat(64'h2203_2202_2201_2200, 1'b0);
    push_beat(64'h2207_2206_2205_2204, 1'b1);
    launch(13'h0200, 16'd2);
    for (i = 0; i < 100; i++) begin
      if (reqs_seen >= 5) break;
      @(posedge clk); #1;
    end
    chk("rst_five_issued", 64'(reqs_seen), 64'd5);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_quiet("midrst");
    chk("midrst_beats_pending", 64'(exp_q.size()), 64'd1);
    exp_q.delete();
    addr_q.delete();
    repeat (3) @(negedge clk);
    check_quiet("midrst_settled");

    push_addrs(13'h0010, 4);
    push_beat(64'h0004_0003_0002_0001, 1'b1);
    launch(13'h0010, 16'd1);
    wait_done("after_rst");
    chk("after_rst_first_valid", 64'(first_valid), 64'd7);
    chk("after_rst_done_cycle", 64'(done_rel), 64'd8);

    // start while busy is ignored
    push_addrs(13'h0010, 4);
    push_beat(64'h0004_0003_0002_0001, 1'b1);
    launch(13'h0010, 16'd1);
    @(posedge clk); #1;
    start     = 1'b1;
    base_addr = 13'h0300;
    num_beats = 16'd5;
    @(posedge clk); #1;
    start     = 1'b0;
    base_addr = '0;
    num_beats = '0;
    wait_done("busy_start");
    chk("busy_start_req_count", 64'(reqs_seen), 64'd4);
    chk("busy_start_done_cycle", 64'(done_rel), 64'd8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish before 500000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ram_store_packer.md
RAM_STORE_PACKER -- requirements
Module: ram_store_packer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, meaning the banked-RAM word width.
REQ-002 SHALL have parameter MEM_DATA_WIDTH, default 64, meaning the output beat width; it SHALL be an integer multiple of DATA_WIDTH, with GROUP_SIZE = MEM_DATA_WIDTH/DATA_WIDTH.
REQ-003 SHALL have parameter ADDR_WIDTH, default 13, meaning the RAM word-address width.
REQ-004 SHALL have parameter CNT_W, default 16, meaning the beat-count width.
REQ-005 SHALL have ports, one per line:
 clk  in  1  clock; all logic on rising edge.
 reset  in  1  reset, synchronous, active-high.
 start  in  1  launch a transfer; sampled only in IDLE.
 base_addr  in  ADDR_WIDTH  first word address, captured on start.
 num_beats  in  CNT_W  number of output beats, captured on start.
 busy  out  1  high in any state other than IDLE.
 done  out  1  one-cycle completion pulse.
 ram_read_req  out  1  read request to RAM read port A.
 ram_read_addr  out  ADDR_WIDTH  read word address.
 ram_read_data  in  DATA_WIDTH  read data, valid exactly one cycle after ram_read_req.
 m_valid  out  1  output beat valid.
 m_ready  in  1  downstream accept.
 m_data  out  MEM_DATA_WIDTH  packed beat.
 m_last  out  1  final beat of the transfer; qualified by m_valid.

Function
REQ-006 SHALL implement FSM states IDLE, RUN, FLUSH, DONE.
REQ-007 IDLE->RUN SHALL occur on start=1; IDLE->DONE SHALL occur on start=1 with num_beats=0. start SHALL be ignored outside IDLE.
REQ-008 RUN->FLUSH SHALL occur when the final word read is issued. FLUSH->DONE SHALL occur on the handshake (m_valid&m_ready) of the beat carrying m_last. DONE->IDLE SHALL occur unconditionally after one cycle.
REQ-009 done SHALL be 1 exactly in the DONE-state cycle.
REQ-010 Total words SHALL be num_beats*GROUP_SIZE. Word i SHALL be read from (base_addr+i) mod 2^ADDR_WIDTH; the address SHALL wrap silently.
REQ-011 ram_read_req SHALL be 1 in a RUN cycle iff issued_words < total_words and pack_cnt + inflight < GROUP_SIZE, where inflight is ram_read_req registered one cycle.
REQ-012 When inflight=1, ram_read_data SHALL be written into the pack register at word slot pack_cnt, and pack_cnt SHALL increment.
REQ-013 Slot k SHALL occupy bits [k*DATA_WIDTH +: DATA_WIDTH]; word 0 (the lowest address of the group) SHALL be in the LSBs.
REQ-014 When pack_cnt = GROUP_SIZE and (m_valid=0 or m_ready=1), the pack register SHALL transfer to the output register, m_valid SHALL become 1 on the next cycle, and pack_cnt SHALL clear to 0 in that same cycle.
REQ-015 If the condition in REQ-014 does not hold, the pack register SHALL hold and no reads SHALL issue (backpressure).
REQ-016 m_data and m_last SHALL remain stable while m_valid=1 and m_ready=0.
REQ-017 m_valid SHALL drop after a handshake unless a new transfer occurs in the same cycle.
REQ-018 m_last SHALL be 1 only on beat number num_beats.
REQ-019 Latency with GROUP_SIZE=4 and m_ready=1: start in cycle 0 -> reads in cycles 1..4 -> first m_valid in cycle 7 -> the next group's reads begin in cycle 7.

Reset
REQ-020 reset SHALL return the FSM to IDLE from any state, including mid-transfer, and discard pack and output contents.
REQ-021 reset SHALL clear to 0 busy, done, ram_read_req, m_valid, m_last, pack_cnt, inflight and all counters.
REQ-022 ram_read_data arriving in the cycle after reset SHALL be ignored.

Verification
REQ-023 RAM[0x10..0x13]=1,2,3,4; base=0x10, beats=1, m_ready=1 -> reads in cycles 1-4 at 0x10-0x13; m_data=0x0004_0003_0002_0001 with m_valid and m_last in cycle 7; done in cycle 8.
REQ-024 base=0x1FFE, beats=1 -> read addresses 0x1FFE, 0x1FFF, 0x0000, 0x0001.
REQ-025 beats=3, m_ready held 0 for 10 cycles after the first m_valid -> beat 1 is held stable; at most 4 further reads issue; no data is lost; all 3 beats arrive in order, with m_last on beat 3 only.
REQ-026 num_beats=0 -> no ram_read_req; m_valid never set; done in cycle 1.
REQ-027 reset asserted in the cycle after 5 of 8 words have issued -> next cycle shows IDLE with all outputs 0; a fresh start then completes correctly.
REQ-028 start pulsed while busy -> ignored; base_addr and num_beats are unchanged for the current transfer.
